// File: rtl/compare_sequencer.sv
// compare_sequencer: MSB-first magnitude compare of two WIDTH-bit words, two bits per cycle,
// through an external 2-bit comparator slice. Optional macro EARLY_EXIT_EN ends the scan at the first LT/GT slice.

module compare_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             SA,
    output logic             SB,
    output logic             SC,
    output logic             SD,
    input  logic             EQ_IN,
    input  logic             LT_IN,
    input  logic             GT_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic             LT,
    output logic             GT,
    output logic             ERR
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_xr;
    logic [WIDTH-1:0] r_yr;
    logic [IW-1:0]    r_idx;
    logic             r_err_acc;
    logic             r_dec_vld;
    logic             r_dec_lt;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;
    logic             r_err;

    logic             w_legal;
    logic             w_slice_lt;
    logic             w_slice_gt;
    logic             w_idx_zero;
    logic             w_fin_go;
    logic             w_err_nxt;
    logic             w_dec_vld_nxt;
    logic             w_dec_lt_nxt;
    logic             w_res_eq;
    logic             w_res_lt;
    logic             w_res_gt;
    logic [1:0]       w_x_pair;
    logic [1:0]       w_y_pair;

    // A slice response is legal only when exactly one of EQ/LT/GT is asserted.
    function automatic logic onehot3(input logic a, input logic b, input logic c);
        return (a ^ b ^ c) & ~(a & b & c);
    endfunction

    assign w_x_pair   = r_xr[{r_idx, 1'b0} +: 2];
    assign w_y_pair   = r_yr[{r_idx, 1'b0} +: 2];
    assign w_legal    = onehot3(EQ_IN, LT_IN, GT_IN);
    assign w_slice_lt = w_legal & LT_IN;
    assign w_slice_gt = w_legal & GT_IN;
    assign w_idx_zero = (r_idx == IW'(0));

    // Next-state, scan termination and final-result selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_fin_go      = 1'b0;
        w_err_nxt     = r_err_acc;
        w_dec_vld_nxt = r_dec_vld;
        w_dec_lt_nxt  = r_dec_lt;
        w_res_eq      = 1'b0;
        w_res_lt      = 1'b0;
        w_res_gt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // An illegal response is flagged and otherwise behaves like an EQ slice.
                if (!w_legal) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = r_err_acc;
                end
`ifdef EARLY_EXIT_EN
                if (w_slice_lt || w_slice_gt) begin
                    w_fin_go = 1'b1;
                    w_res_lt = w_slice_lt;
                    w_res_gt = w_slice_gt;
                end else if (w_idx_zero) begin
                    w_fin_go = 1'b1;
                    w_res_eq = 1'b1;
                end else begin
                    w_fin_go = 1'b0;
                end
`else
                if (!r_dec_vld && (w_slice_lt || w_slice_gt)) begin
                    w_dec_vld_nxt = 1'b1;
                    w_dec_lt_nxt  = w_slice_lt;
                end else begin
                    w_dec_vld_nxt = r_dec_vld;
                    w_dec_lt_nxt  = r_dec_lt;
                end
                if (w_idx_zero) begin
                    w_fin_go = 1'b1;
                    w_res_eq = ~w_dec_vld_nxt;
                    w_res_lt = w_dec_vld_nxt & w_dec_lt_nxt;
                    w_res_gt = w_dec_vld_nxt & ~w_dec_lt_nxt;
                end else begin
                    w_fin_go = 1'b0;
                end
`endif
                if (w_fin_go) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, slice index walk, accumulators and the registered result.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_xr      <= {WIDTH{1'b0}};
            r_yr      <= {WIDTH{1'b0}};
            r_idx     <= {IW{1'b0}};
            r_err_acc <= 1'b0;
            r_dec_vld <= 1'b0;
            r_dec_lt  <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_xr      <= X;
                        r_yr      <= Y;
                        r_idx     <= IW'(N - 1);
                        r_err_acc <= 1'b0;
                        r_dec_vld <= 1'b0;
                        r_dec_lt  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_err_acc <= w_err_nxt;
                    r_dec_vld <= w_dec_vld_nxt;
                    r_dec_lt  <= w_dec_lt_nxt;
                    if (w_fin_go) begin
                        r_eq  <= w_res_eq;
                        r_lt  <= w_res_lt;
                        r_gt  <= w_res_gt;
                        r_err <= w_err_nxt;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Slice drive: current bit pairs while scanning, quiet zeros otherwise.
    always_comb begin
        if (r_state == ST_SCAN) begin
            {SA, SB} = w_x_pair;
            {SC, SD} = w_y_pair;
        end else begin
            {SA, SB} = 2'b00;
            {SC, SD} = 2'b00;
        end
    end

    assign BUSY = (r_state == ST_SCAN);
    assign DONE = (r_state == ST_FIN);
    assign EQ   = r_eq;
    assign LT   = r_lt;
    assign GT   = r_gt;
    assign ERR  = r_err;

endmodule

// File: tb/tb_compare_sequencer.sv
// Bench for compare_sequencer: a transaction-level model predicts every cycle's outputs,
// directed cases pin latency and result literals, then random traffic with resets and faults.

module tb_compare_sequencer;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             SA, SB, SC, SD;
    logic             EQ_IN, LT_IN, GT_IN;
    logic             BUSY, DONE, EQ, LT, GT, ERR;

    int vectors     = 0;
    int miscompares = 0;
    logic chk_en    = 1'b0;

    // Model state: scan cycles left, scan cycles done, pending/visible result {EQ,LT,GT,ERR}.
    int               m_left = 0;
    int               m_cyc  = 0;
    logic             m_done = 1'b0;
    logic [3:0]       m_res  = 4'b0000;
    logic [3:0]       m_pend = 4'b0000;
    logic [WIDTH-1:0] m_x    = '0;
    logic [WIDTH-1:0] m_y    = '0;
    logic [N-1:0]     m_inj  = '0;
    logic [N-1:0]     inj_mask;

    logic [1:0] e_a, e_b;
    logic       inj_now;
    int         e_idx;

    compare_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .X(X), .Y(Y),
        .SA(SA), .SB(SB), .SC(SC), .SD(SD),
        .EQ_IN(EQ_IN), .LT_IN(LT_IN), .GT_IN(GT_IN),
        .BUSY(BUSY), .DONE(DONE), .EQ(EQ), .LT(LT), .GT(GT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Comparator slice, with a dead (all-zero) response on slices selected for fault injection.
    always_comb begin
        e_a     = {SA, SB};
        e_b     = {SC, SD};
        e_idx   = N - 1 - m_cyc;
        inj_now = 1'b0;
        if (m_left > 0 && e_idx >= 0 && e_idx < N) inj_now = m_inj[e_idx];
        if (inj_now) {EQ_IN, LT_IN, GT_IN} = 3'b000;
        else         {EQ_IN, LT_IN, GT_IN} = {e_a == e_b, e_a < e_b, e_a > e_b};
    end

    // Dead slices count as equal, so the answer is a plain compare of the masked words.
    function automatic void predict(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [N-1:0] inj, output int j, output logic [3:0] res);
        logic [WIDTH-1:0] xm, ym;
        int first;
        logic err;
        xm = x; ym = y; first = -1; err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (inj[i]) begin
                xm[2*i +: 2] = 2'b00;
                ym[2*i +: 2] = 2'b00;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (first < 0 && xm[2*i +: 2] != ym[2*i +: 2]) first = i;
        end
`ifdef EARLY_EXIT_EN
        j = (first < 0) ? N : N - first;
`else
        j = N;
`endif
        for (int i = N - 1; i >= N - j; i--) begin
            if (inj[i]) err = 1'b1;
        end
        res = {xm == ym, xm < ym, xm > ym, err};
    endfunction

    always @(posedge CLK) begin : model
        int         j;
        logic [3:0] r;
        if (!RST_N) begin
            m_left <= 0; m_cyc <= 0; m_done <= 1'b0; m_res <= 4'b0000;
            m_x <= '0; m_y <= '0; m_inj <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_cyc  <= m_cyc + 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (START) begin
            predict(X, Y, inj_mask, j, r);
            m_left <= j; m_pend <= r; m_cyc <= 0;
            m_x <= X; m_y <= Y; m_inj <= inj_mask;
        end
    end

    // Every cycle: full output vector against the model.
    always @(negedge CLK) begin
        logic [3:0] exp_sl;
        int         ix;
        if (chk_en) begin
            ix     = N - 1 - m_cyc;
            exp_sl = 4'b0000;
            if (m_left > 0 && ix >= 0) exp_sl = {m_x[2*ix +: 2], m_y[2*ix +: 2]};
            vectors++;
            if ({BUSY, DONE, EQ, LT, GT, ERR, SA, SB, SC, SD} !== {m_left > 0, m_done, m_res, exp_sl}) begin
                miscompares++;
                $display("FAIL cycle t=%0t busy/done/eq/lt/gt/err/slice got %b%b_%b%b%b%b_%b%b%b%b want %b%b_%b_%b",
                         $time, BUSY, DONE, EQ, LT, GT, ERR, SA, SB, SC, SD,
                         m_left > 0, m_done, m_res, exp_sl);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // One comparison: START for one edge, bounded wait for DONE, then the FIN->IDLE edge.
    task automatic run_cmp(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic [N-1:0] inj, input int exp_lat, input logic [3:0] exp_res);
        int n;
        X = x; Y = y; inj_mask = inj; START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (DONE !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_lit({name, " latency"}, 32'(n), 32'(exp_lat));
        check_lit({name, " result"}, 32'({EQ, LT, GT, ERR}), 32'(exp_res));
        check_lit({name, " model"}, 32'(m_res), 32'(exp_res));
        tick();
    endtask

    initial begin
        int dones;
        RST_N = 1'b0; START = 1'b1; X = 8'h5A; Y = 8'h11; inj_mask = '0;
        tick();
        tick();
        chk_en = 1'b1;
        check_lit("reset outputs", 32'({BUSY, DONE, EQ, LT, GT, ERR, SA, SB, SC, SD}), 32'd0);
        START = 1'b0; RST_N = 1'b1;
        tick();

        run_cmp("equal A5", 8'hA5, 8'hA5, 4'b0000, 4, 4'b1000);
`ifdef EARLY_EXIT_EN
        run_cmp("msb 80>7F", 8'h80, 8'h7F, 4'b0000, 1, 4'b0010);
`else
        run_cmp("msb 80>7F", 8'h80, 8'h7F, 4'b0000, 4, 4'b0010);
`endif
        run_cmp("lsb 12<13", 8'h12, 8'h13, 4'b0000, 4, 4'b0100);
        run_cmp("illegal 3C", 8'h3C, 8'h3C, 4'b1000, 4, 4'b1001);
        run_cmp("legal 3C", 8'h3C, 8'h3C, 4'b0000, 4, 4'b1000);

        // START held for ten edges: only IDLE re-samples it, so comparisons never overlap.
        X = 8'h00; Y = 8'hFF; START = 1'b1; dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) START = 1'b0;
            tick();
            if (DONE === 1'b1) dones++;
        end
`ifdef EARLY_EXIT_EN
        check_lit("held start dones", 32'(dones), 32'd4);
`else
        check_lit("held start dones", 32'(dones), 32'd2);
`endif
        check_lit("held start result", 32'({EQ, LT, GT, ERR}), 32'b0100);

        // Reset two edges into a scan: everything clears and no DONE follows.
        X = 8'h12; Y = 8'h13; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check_lit("midscan reset", 32'({BUSY, DONE, EQ, LT, GT, ERR, SA, SB, SC, SD}), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (DONE === 1'b1) dones++;
        end
        check_lit("no done after reset", 32'(dones), 32'd0);

        // Random traffic with near-equal operands, dead slices and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            START = ($urandom_range(2) == 0);
            X = 8'($urandom);
            case ($urandom_range(3))
                0:       Y = X;
                1:       Y = X ^ (8'h01 << $urandom_range(7));
                default: Y = 8'($urandom);
            endcase
            inj_mask = ($urandom_range(4) == 0) ? N'($urandom) : '0;
            RST_N = ($urandom_range(199) != 0);
            tick();
        end
        RST_N = 1'b1; START = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
